// File: rtl/alu_forwarding_unit.sv
// MEM/WB result pipeline that feeds the ALU operand forward muxes, detects
// load-use hazards and drives the register-file write-back port.
module alu_forwarding_unit #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic            flush,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  output logic            reg_data_select,
  output logic [XLEN-1:0] fwd_data_a,
  output logic            fwd_sel_b,
  output logic [XLEN-1:0] fwd_data_b,
  output logic            stall,
  output logic            wb_we,
  output logic [RA_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data
);

  logic            m_valid, m_we, m_load;
  logic [RA_W-1:0] m_rd;
  logic [XLEN-1:0] m_result;
  logic            w_valid, w_we;
  logic [RA_W-1:0] w_rd;
  logic [XLEN-1:0] w_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_we     <= 1'b0;
      m_load   <= 1'b0;
      m_rd     <= '0;
      m_result <= '0;
      w_valid  <= 1'b0;
      w_we     <= 1'b0;
      w_rd     <= '0;
      w_data   <= '0;
    end else begin
      m_valid  <= ex_valid & ~flush;
      // Clearing the write enable for x0 is what keeps x0 from ever forwarding.
      m_we     <= ex_reg_write & (ex_rd != '0);
      m_load   <= ex_mem_read;
      m_rd     <= ex_rd;
      m_result <= ex_alu_result;
      w_valid  <= m_valid;
      w_we     <= m_we;
      w_rd     <= m_rd;
      w_data   <= m_load ? mem_load_data : m_result;
    end
  end

  assign wb_we   = w_valid & w_we;
  assign wb_rd   = w_rd;
  assign wb_data = w_data;

  logic [RA_W-1:0] src [2];
  logic [1:0]      src_used;
  logic [1:0]      fwd_sel;
  logic [XLEN-1:0] fwd_data [2];
  logic [1:0]      load_hit;

  assign src[0]   = id_rs1;
  assign src[1]   = id_rs2;
  assign src_used = {id_use_rs2, id_use_rs1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      logic hit_m, hit_w;
      assign hit_m        = m_valid & m_we & (m_rd == src[gi]) & ~m_load;
      assign hit_w        = w_valid & w_we & (w_rd == src[gi]);
      assign load_hit[gi] = m_valid & m_we & m_load & src_used[gi] & (m_rd == src[gi]);
      // A pending load shadows any older WB copy of the same register.
      assign fwd_sel[gi]  = hit_m | (hit_w & ~load_hit[gi]);
      assign fwd_data[gi] = hit_m ? m_result :
                            (hit_w & ~load_hit[gi]) ? w_data : '0;
    end
  endgenerate

  assign stall           = |load_hit;
  assign reg_data_select = fwd_sel[0];
  assign fwd_data_a      = fwd_data[0];
  assign fwd_sel_b       = fwd_sel[1];
  assign fwd_data_b      = fwd_data[1];

endmodule

// File: tb/tb_alu_forwarding_unit.sv
// Directed-vector bench for alu_forwarding_unit with hand-computed expectations.
module tb_alu_forwarding_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_reg_write, ex_mem_read, flush;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic [31:0] ex_alu_result, mem_load_data;
  logic        id_use_rs1, id_use_rs2;
  logic        reg_data_select, fwd_sel_b, stall, wb_we;
  logic [31:0] fwd_data_a, fwd_data_b, wb_data;
  logic [4:0]  wb_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_forwarding_unit #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_alu_result(ex_alu_result), .flush(flush),
    .mem_load_data(mem_load_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .reg_data_select(reg_data_select), .fwd_data_a(fwd_data_a),
    .fwd_sel_b(fwd_sel_b), .fwd_data_b(fwd_data_b),
    .stall(stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd, input logic rw,
                        input logic ld, input logic [31:0] res, input logic fl);
    ex_valid = v; ex_rd = rd; ex_reg_write = rw;
    ex_mem_read = ld; ex_alu_result = res; flush = fl;
  endtask

  task automatic set_id(input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2);
    id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    mem_load_data = '0;
    set_ex(0, 0, 0, 0, 0, 0);
    set_id(0, 0, 0, 0);
    tick; tick;
    check("rst_sel_a", {31'd0, reg_data_select}, 0);
    check("rst_sel_b", {31'd0, fwd_sel_b}, 0);
    check("rst_stall", {31'd0, stall}, 0);
    check("rst_wb_we", {31'd0, wb_we}, 0);
    check("rst_wb_rd", {27'd0, wb_rd}, 0);
    check("rst_wb_data", wb_data, 0);
    rst = 1'b0;
    tick;

    // Back-to-back dependency on x5
    set_ex(1, 5, 1, 0, 32'h10, 0);
    tick;
    set_ex(0, 0, 0, 0, 0, 0);
    set_id(5, 1, 0, 0);
    #1;
    check("d1_sel_a", {31'd0, reg_data_select}, 1);
    check("d1_data_a", fwd_data_a, 32'h10);
    check("d1_stall", {31'd0, stall}, 0);
    tick;
    check("d2_sel_a", {31'd0, reg_data_select}, 1);
    check("d2_data_a", fwd_data_a, 32'h10);
    check("d2_wb_we", {31'd0, wb_we}, 1);
    check("d2_wb_rd", {27'd0, wb_rd}, 5);
    check("d2_wb_data", wb_data, 32'h10);
    tick;
    check("d3_sel_a", {31'd0, reg_data_select}, 0);
    check("d3_wb_we", {31'd0, wb_we}, 0);

    // Double hazard on x7, MEM copy wins
    set_ex(1, 7, 1, 0, 32'h11, 0);
    tick;
    set_ex(1, 7, 1, 0, 32'h22, 0);
    tick;
    set_ex(0, 0, 0, 0, 0, 0);
    set_id(0, 0, 7, 1);
    #1;
    check("dbl_sel_b", {31'd0, fwd_sel_b}, 1);
    check("dbl_data_b", fwd_data_b, 32'h22);
    check("dbl_wb_data", wb_data, 32'h11);
    tick;
    check("dbl_w_sel_b", {31'd0, fwd_sel_b}, 1);
    check("dbl_w_data_b", fwd_data_b, 32'h22);

    // x0 destination never forwards or writes
    set_ex(1, 0, 1, 0, 32'hDEAD, 0);
    tick;
    set_ex(0, 0, 0, 0, 0, 0);
    set_id(0, 1, 0, 1);
    #1;
    check("x0_sel_a", {31'd0, reg_data_select}, 0);
    check("x0_data_a", fwd_data_a, 0);
    tick;
    check("x0_wb_we", {31'd0, wb_we}, 0);

    // Load-use on x3
    set_ex(1, 3, 1, 1, 32'h100, 0);
    tick;
    set_ex(0, 0, 0, 0, 0, 0);
    set_id(3, 1, 0, 0);
    #1;
    check("lu_stall", {31'd0, stall}, 1);
    check("lu_sel_a", {31'd0, reg_data_select}, 0);
    set_id(3, 0, 0, 0);
    #1;
    check("lu_unused_stall", {31'd0, stall}, 0);
    set_id(0, 0, 3, 1);
    #1;
    check("lu_rs2_stall", {31'd0, stall}, 1);
    check("lu_rs2_sel_b", {31'd0, fwd_sel_b}, 0);
    set_id(3, 1, 0, 0);
    mem_load_data = 32'hCAFE_F00D;
    tick;
    mem_load_data = '0;
    #1;
    check("lu_w_stall", {31'd0, stall}, 0);
    check("lu_w_sel_a", {31'd0, reg_data_select}, 1);
    check("lu_w_data_a", fwd_data_a, 32'hCAFE_F00D);
    check("lu_wb_rd", {27'd0, wb_rd}, 3);
    check("lu_wb_data", wb_data, 32'hCAFE_F00D);
    tick;

    // Flush kills the EX capture of x9
    set_ex(1, 9, 1, 0, 32'h99, 1);
    tick;
    set_ex(0, 0, 0, 0, 0, 0);
    set_id(9, 1, 9, 1);
    #1;
    check("fl_sel_a", {31'd0, reg_data_select}, 0);
    check("fl_sel_b", {31'd0, fwd_sel_b}, 0);
    tick;
    check("fl_wb_we", {31'd0, wb_we}, 0);

    // Reset with instructions in MEM and WB
    set_ex(1, 10, 1, 0, 32'hA, 0);
    tick;
    set_ex(1, 11, 1, 0, 32'hB, 0);
    tick;
    set_ex(0, 0, 0, 0, 0, 0);
    set_id(11, 1, 10, 1);
    #1;
    check("mf_pre_wb_we", {31'd0, wb_we}, 1);
    check("mf_pre_sel_a", {31'd0, reg_data_select}, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mf_sel_a", {31'd0, reg_data_select}, 0);
    check("mf_sel_b", {31'd0, fwd_sel_b}, 0);
    check("mf_data_a", fwd_data_a, 0);
    check("mf_wb_we", {31'd0, wb_we}, 0);
    check("mf_wb_rd", {27'd0, wb_rd}, 0);
    check("mf_wb_data", wb_data, 0);
    tick;
    check("mf_post_wb_we", {31'd0, wb_we}, 0);
    check("mf_post_sel_a", {31'd0, reg_data_select}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_forwarding_unit.md
# alu_forwarding_unit

Result-side counterpart of the ALU input muxes. Captures each ALU result into two pipeline stages, MEM and WB, and tracks the destination register of each. From these stages it produces the forwarded operand data and the forward-select signals that the operand-A and operand-B muxes consume. It also detects load-use hazards, raises a one-cycle stall, and drives the register-file write-back port.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register-address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX stage holds a live instruction this cycle
- ex_rd  in  RA_W  destination register of EX instruction
- ex_reg_write  in  1  EX instruction writes rd
- ex_mem_read  in  1  EX instruction is a load
- ex_alu_result  in  XLEN  ALU output (address for loads)
- flush  in  1  kill the EX instruction being captured this edge
- mem_load_data  in  XLEN  load data for the MEM-stage load, valid in the same cycle
- id_rs1, id_rs2  in  RA_W  source registers of the instruction in ID/EX operand select
- id_use_rs1, id_use_rs2  in  1  source actually read
- reg_data_select  out  1  operand-A forward enable (1 = use fwd_data_a)
- fwd_data_a  out  XLEN  forwarded operand A
- fwd_sel_b  out  1  operand-B forward enable
- fwd_data_b  out  XLEN  forwarded operand B
- stall  out  1  load-use hazard; upstream holds ID and injects ex_valid=0 next cycle
- wb_we  out  1  register-file write enable
- wb_rd  out  RA_W  write address
- wb_data  out  XLEN  write data

## Operation
- **MEM register, captured every edge.**
  - Fields: m_valid, m_rd, m_we, m_load, m_result.
  - m_valid <= ex_valid & ~flush & ~rst.
  - m_we <= ex_reg_write & (ex_rd != 0).
- **WB register, captured every edge.**
  - Fields: w_valid, w_rd, w_we, w_data.
  - w_data <= m_load ? mem_load_data : m_result.
  - w_valid <= m_valid & ~rst.
- **Write-back outputs.**
  - wb_we = w_valid & w_we.
  - wb_rd = w_rd, wb_data = w_data.
- **Stage hit, per source s (s = rs1 or rs2).**
  - hitM(s) = m_valid & m_we & (m_rd == s) & ~m_load.
  - hitW(s) = w_valid & w_we & (w_rd == s).
- **Forward priority, per operand:**
  - hitM wins; data = m_result.
  - Otherwise hitW; data = w_data.
  - Otherwise select = 0 and data = 0.
  - Register x0 never forwards, because m_we and w_we are cleared when rd = 0.
- **Load-use stall.**
  - stall = m_valid & m_we & m_load & ((id_use_rs1 & m_rd == id_rs1) | (id_use_rs2 & m_rd == id_rs2)).
  - While stall is high, the forward select for the affected operand is 0.
  - Next cycle the load is in WB, and hitW forwards the load data.
- **Stall response.** The block keeps advancing its stages during a stall. Upstream supplies the bubble by driving ex_valid = 0.
- **Flush.** Affects only the instruction being captured into MEM. An instruction already in MEM or WB completes.
- **Simultaneous flush and stall.** Flush clears m_valid for the EX capture; the stall is still reported from current MEM state.

## Timing
- **Forward and stall outputs.** Combinational from the MEM/WB registers and the id_* inputs; no added latency.
- **Distance 1.** The result in MEM is forwarded in the cycle after the ALU computes it.
- **Distance 2.** The result in WB is forwarded in the following cycle.
- **Distance 3 and beyond.** No forward; the register-file write lands on the edge that closes the WB cycle.
- **Write-back latency.** wb_* is valid 2 cycles after the EX cycle (EX -> MEM -> WB).
- **Reset.**
  - Effect at the first edge with rst = 1: all valid bits 0, all data and rd fields 0.
  - Outputs while held in reset: reg_data_select, fwd_sel_b, stall and wb_we = 0; fwd_data_a/b, wb_rd and wb_data = 0.
  - Reset mid-operation discards both in-flight stages; no write-back occurs.

## Test plan
- **Back-to-back dependency.** EX1: rd=x5, result 0x0000_0010, reg_write=1. Next cycle id_rs1=x5 -> reg_data_select=1, fwd_data_a=0x10. Two cycles later wb_we=1, wb_rd=5, wb_data=0x10.
- **Double hazard, MEM wins.** x7 in WB holds 0x11; x7 in MEM holds 0x22; id_rs2=x7 -> fwd_sel_b=1, fwd_data_b=0x22.
- **x0 destination.** ALU writes rd=x0 with 0xDEAD; id_rs1=x0 -> reg_data_select=0, and wb_we stays 0.
- **Load-use.**
  - Load rd=x3 in MEM, id_rs1=x3 -> stall=1, reg_data_select=0.
  - Next cycle ex_valid=0 and mem_load_data=0xCAFE_F00D was captured -> stall=0, reg_data_select=1, fwd_data_a=0xCAFE_F00D.
- **Flush.** ex_valid=1 with flush=1, rd=x9 -> m_valid=0; id_rs1=x9 next cycle gives no forward; no write to x9.
- **Reset mid-flight.** Instructions in MEM and WB; assert rst for 1 cycle -> all outputs 0 on the following cycle, and neither instruction is written back.
